// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

   localparam int unsigned BURST_W = 4;

   // One-hot ownership states.
   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      OWN0 = 4'b0010,
      OWN1 = 4'b0100,
      TURN = 4'b1000
   } arb_state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // SRAM strobes are active-low.
   localparam logic ENA    = 1'b0;
   localparam logic DISENA = 1'b1;

   // Read-return tag: which port issued an outstanding read.
   typedef struct packed {
      logic vld;
      logic id;
   } rd_tag_t;

endpackage

// File: rtl/sram_arb_rdpipe.sv
// Fixed-latency {valid, id} delay line that steers SRAM read data back to its issuer.
module sram_arb_rdpipe
   import sram_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = 2
) (
   input  logic    clk,
   input  logic    reset_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t pipe_q [RD_LAT];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= tag_in;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/sram_arb.sv
// Round-robin, burst-limited arbiter sharing one SRAM port between two requesters.
// Optional grant statistics counters are built when ARB_STATS_EN is defined.
module sram_arb
   import sram_arb_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned MAX_BURST = 4
) (
`ifdef ARB_STATS_EN
   input  logic              stat_clr,
   output logic [31:0]       stat_gnt0,
   output logic [31:0]       stat_gnt1,
`endif
   input  logic              clk,
   input  logic              reset_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              s_cen,
   output logic              s_wen,
   output logic              s_oen,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_ddata,
   input  logic [DATA_W-1:0] s_qdata,
   output logic              s_clk
);

   arb_state_e         state_q, state_d;
   logic               rr_q, rr_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic               limit_hit;

   logic               gnt_any;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   rd_tag_t            tag_in, tag_out;

   assign s_clk = clk;

   // Ownership state, round-robin pointer and burst counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rr_q    <= PORT0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         burst_q <= burst_d;
      end
   end

   // Next-state and combinational grants; the burst limit only bites while the other port waits.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      burst_d   = burst_q;
      r0_gnt    = 1'b0;
      r1_gnt    = 1'b0;
      limit_hit = (burst_q >= BURST_W'(MAX_BURST - 1));

      case (state_q)
         IDLE: begin
            burst_d = '0;
            if (r0_req && r1_req) begin
               state_d = (rr_q == PORT1) ? OWN1 : OWN0;
            end else if (r0_req) begin
               state_d = OWN0;
            end else if (r1_req) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            r0_gnt = r0_req;
            if (!r0_req || (limit_hit && r1_req)) begin
               state_d = TURN;
               rr_d    = PORT1;
            end else if (burst_q != '1) begin
               burst_d = burst_q + BURST_W'(1);
            end
         end
         OWN1: begin
            r1_gnt = r1_req;
            if (!r1_req || (limit_hit && r0_req)) begin
               state_d = TURN;
               rr_d    = PORT0;
            end else if (burst_q != '1) begin
               burst_d = burst_q + BURST_W'(1);
            end
         end
         TURN: begin
            burst_d = '0;
            if (rr_q == PORT1) begin
               state_d = r1_req ? OWN1 : IDLE;
            end else begin
               state_d = r0_req ? OWN0 : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign gnt_any   = r0_gnt | r1_gnt;
   assign sel_we    = r1_gnt ? r1_we    : r0_we;
   assign sel_addr  = r1_gnt ? r1_addr  : r0_addr;
   assign sel_wdata = r1_gnt ? r1_wdata : r0_wdata;

   // SRAM pin register: launch the granted access, otherwise deselect and hold address/data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_cen   <= DISENA;
         s_wen   <= DISENA;
         s_oen   <= DISENA;
         s_addr  <= '0;
         s_ddata <= '0;
      end else if (gnt_any) begin
         s_cen  <= ENA;
         s_wen  <= ~sel_we;
         s_oen  <= sel_we;
         s_addr <= sel_addr;
         if (sel_we) begin
            s_ddata <= sel_wdata;
         end
      end else begin
         s_cen <= DISENA;
         s_wen <= DISENA;
         s_oen <= DISENA;
      end
   end

   assign tag_in.vld = gnt_any & ~sel_we;
   assign tag_in.id  = r1_gnt ? PORT1 : PORT0;

   sram_arb_rdpipe #(
      .RD_LAT (RD_LAT)
   ) u_rdpipe (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Read return: capture s_qdata for the issuing port when its tag exits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         r0_rdata  <= '0;
         r1_rdata  <= '0;
      end else begin
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         if (tag_out.vld) begin
            if (tag_out.id == PORT1) begin
               r1_rvalid <= 1'b1;
               r1_rdata  <= s_qdata;
            end else begin
               r0_rvalid <= 1'b1;
               r0_rdata  <= s_qdata;
            end
         end
      end
   end

`ifdef ARB_STATS_EN
   // Saturating grant counters; clear wins over increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_gnt0 <= '0;
         stat_gnt1 <= '0;
      end else if (stat_clr) begin
         stat_gnt0 <= '0;
         stat_gnt1 <= '0;
      end else begin
         if (r0_gnt && (stat_gnt0 != '1)) begin
            stat_gnt0 <= stat_gnt0 + 32'd1;
         end
         if (r1_gnt && (stat_gnt1 != '1)) begin
            stat_gnt1 <= stat_gnt1 + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: SRAM model plus a read-return scoreboard.
module tb_sram_arb;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned RD_LAT    = 2;
   localparam int unsigned MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              r0_req, r0_we, r1_req, r1_we;
   logic [ADDR_W-1:0] r0_addr, r1_addr;
   logic [DATA_W-1:0] r0_wdata, r1_wdata;
   logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [DATA_W-1:0] r0_rdata, r1_rdata;
   logic              s_cen, s_wen, s_oen, s_clk;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_ddata, s_qdata;
`ifdef ARB_STATS_EN
   logic              stat_clr;
   logic [31:0]       stat_gnt0, stat_gnt1;
`endif

   always #5 clk = ~clk;

   sram_arb #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .RD_LAT    (RD_LAT),
      .MAX_BURST (MAX_BURST)
   ) dut (
`ifdef ARB_STATS_EN
      .stat_clr  (stat_clr),
      .stat_gnt0 (stat_gnt0),
      .stat_gnt1 (stat_gnt1),
`endif
      .clk       (clk),
      .reset_n   (reset_n),
      .r0_req    (r0_req),
      .r0_we     (r0_we),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_gnt    (r0_gnt),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_req    (r1_req),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_gnt    (r1_gnt),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata),
      .s_cen     (s_cen),
      .s_wen     (s_wen),
      .s_oen     (s_oen),
      .s_addr    (s_addr),
      .s_ddata   (s_ddata),
      .s_qdata   (s_qdata),
      .s_clk     (s_clk)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_word(input logic [9:0] a);
      case (a)
         10'h005: return 8'hA5;
         10'h010: return 8'h11;
         default: return a[7:0] ^ {a[9:8], 6'h15};
      endcase
   endfunction

   // SRAM model: write at the strobe edge, read data valid RD_LAT edges after the grant edge.
   logic [7:0] sram [int];
   logic [7:0] q = '0;
   always @(posedge clk) begin
      if (s_cen == 1'b0 && s_wen == 1'b0) sram[int'(s_addr)] = s_ddata;
      if (s_cen == 1'b0 && s_wen == 1'b1)
         q <= sram.exists(int'(s_addr)) ? sram[int'(s_addr)] : init_word(s_addr);
   end
   assign s_qdata = q;

   // Bench-side reference of what each address should hold.
   logic [7:0] ref_mem [int];
   function automatic logic [7:0] exp_word(input logic [9:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
   endfunction

   typedef struct {
      logic       port;
      logic [7:0] data;
      int         cyc;
   } exp_t;
   exp_t sb [$];
   exp_t mon_e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Read-return monitor.
   always @(negedge clk) begin
      if (reset_n) begin
         if (r0_rvalid && r1_rvalid) begin
            chk("rv_both", 32'd1, 32'd0);
         end else if (r0_rvalid || r1_rvalid) begin
            if (sb.size() == 0) begin
               chk("rv_spurious", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("rv_port", 32'(r1_rvalid), 32'(mon_e.port));
               chk("rv_data", 32'(r1_rvalid ? r1_rdata : r0_rdata), 32'(mon_e.data));
               chk("rv_cyc", cyc, mon_e.cyc);
            end
         end
      end
   end

   task automatic set_req(input logic port, input logic req, input logic we,
                          input logic [9:0] addr, input logic [7:0] wdata);
      if (port) begin
         r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
      end else begin
         r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
      end
   endtask

   // One access: request, wait (bounded) for grant, then check the launched pins.
   task automatic access(input logic port, input logic we, input logic [9:0] addr,
                         input logic [7:0] wdata, output int gcyc);
      int   n   = 0;
      logic got = 1'b0;
      gcyc = -1;
      set_req(port, 1'b1, we, addr, wdata);
      while (!got && n < 20) begin
         @(negedge clk);
         if ((port ? r1_gnt : r0_gnt) === 1'b1) begin
            got  = 1'b1;
            gcyc = cyc;
            if (we) ref_mem[int'(addr)] = wdata;
            else sb.push_back('{port, exp_word(addr), cyc + int'(RD_LAT) + 1});
         end
         @(posedge clk); #1;
         n++;
      end
      set_req(port, 1'b0, we, addr, wdata);
      if (!got) begin
         chk("gnt_timeout", 32'd0, 32'd1);
      end else begin
         chk("pin_cen", 32'(s_cen), 32'd0);
         chk("pin_wen", 32'(s_wen), 32'(!we));
         chk("pin_oen", 32'(s_oen), 32'(we));
         chk("pin_addr", 32'(s_addr), 32'(addr));
         if (we) chk("pin_ddata", 32'(s_ddata), 32'(wdata));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int g, g2, n0, n1;
   logic [1:0] gv;
   int exp_pat [17] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1, 1, 0, 0, 2, 2};

   initial begin
      reset_n = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1'b1, 1'b0, 1'b0, '0, '0);
`ifdef ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      idle(3);
      chk("rst_gnt0", 32'(r0_gnt), 32'd0);
      chk("rst_gnt1", 32'(r1_gnt), 32'd0);
      chk("rst_rv0", 32'(r0_rvalid), 32'd0);
      chk("rst_rv1", 32'(r1_rvalid), 32'd0);
      chk("rst_rd0", 32'(r0_rdata), 32'd0);
      chk("rst_rd1", 32'(r1_rdata), 32'd0);
      chk("rst_cen", 32'(s_cen), 32'd1);
      chk("rst_wen", 32'(s_wen), 32'd1);
      chk("rst_oen", 32'(s_oen), 32'd1);
      chk("rst_addr", 32'(s_addr), 32'd0);
      chk("rst_ddata", 32'(s_ddata), 32'd0);
      reset_n = 1'b1;
      idle(1);

      // Single read from port 0.
      access(1'b0, 1'b0, 10'h005, 8'h00, g);
      idle(6);

      // Port 1 writes, port 0 reads back across a TURN cycle.
      access(1'b1, 1'b1, 10'h3FF, 8'h3C, g);
      set_req(1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00);
      @(negedge clk);
      chk("own1_tail_gnt0", 32'(r0_gnt), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("turn_gnt0", 32'(r0_gnt), 32'd0);
      chk("turn_cen", 32'(s_cen), 32'd1);
      chk("turn_oen", 32'(s_oen), 32'd1);
      chk("turn_wen", 32'(s_wen), 32'd1);
      @(posedge clk); #1;
      access(1'b0, 1'b0, 10'h3FF, 8'h00, g2);
      chk("rw_gap", g2 - g, 32'd3);
      idle(6);

      // Port 0 read still in flight when port 1 takes ownership.
      access(1'b0, 1'b0, 10'h010, 8'h00, g);
      set_req(1'b1, 1'b1, 1'b1, 10'h020, 8'h77);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("inflight_gnt1", 32'(r1_gnt), 32'd1);
      chk("inflight_rv0", 32'(r0_rvalid), 32'd1);
      if (r1_gnt === 1'b1) ref_mem[int'(10'h020)] = 8'h77;
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
      idle(6);
      access(1'b1, 1'b0, 10'h020, 8'h00, g);
      idle(6);

      // Reset one cycle after a read grant: the read is dropped.
      access(1'b0, 1'b0, 10'h0AA, 8'h00, g);
      reset_n = 1'b0;
      sb.delete();
      #1;
      chk("mrst_cen", 32'(s_cen), 32'd1);
      chk("mrst_wen", 32'(s_wen), 32'd1);
      chk("mrst_oen", 32'(s_oen), 32'd1);
      chk("mrst_addr", 32'(s_addr), 32'd0);
      idle(2);
      reset_n = 1'b1;
      idle(8);

      // Both ports request 6 writes each, starting from reset (rr prefers port 0).
      n0 = 0;
      n1 = 0;
      set_req(1'b0, 1'b1, 1'b1, 10'h100, 8'h40);
      set_req(1'b1, 1'b1, 1'b1, 10'h200, 8'h80);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         gv = {r1_gnt, r0_gnt};
         chk($sformatf("burst_pat%0d", i), 32'(gv), exp_pat[i]);
         if (r0_gnt === 1'b1) begin
            ref_mem[int'(10'h100) + n0] = 8'h40 + 8'(n0);
            n0++;
         end
         if (r1_gnt === 1'b1) begin
            ref_mem[int'(10'h200) + n1] = 8'h80 + 8'(n1);
            n1++;
         end
         @(posedge clk); #1;
         set_req(1'b0, n0 < 6, 1'b1, 10'h100 + 10'(n0), 8'h40 + 8'(n0));
         set_req(1'b1, n1 < 6, 1'b1, 10'h200 + 10'(n1), 8'h80 + 8'(n1));
      end
      chk("burst_n0", n0, 32'd6);
      chk("burst_n1", n1, 32'd6);
      idle(4);
      access(1'b1, 1'b0, 10'h205, 8'h00, g);
      idle(6);
      access(1'b0, 1'b0, 10'h100, 8'h00, g);
      idle(6);

`ifdef ARB_STATS_EN
      stat_clr = 1'b1;
      idle(1);
      stat_clr = 1'b0;
      chk("stat_clr0_a", stat_gnt0, 32'd0);
      chk("stat_clr1_a", stat_gnt1, 32'd0);
      for (int i = 0; i < 5; i++) access(1'b0, 1'b1, 10'h300 + 10'(i), 8'(i), g);
      for (int i = 0; i < 3; i++) access(1'b1, 1'b1, 10'h310 + 10'(i), 8'(i), g);
      idle(4);
      chk("stat_gnt0", stat_gnt0, 32'd5);
      chk("stat_gnt1", stat_gnt1, 32'd3);
      stat_clr = 1'b1;
      idle(1);
      stat_clr = 1'b0;
      chk("stat_clr0_b", stat_gnt0, 32'd0);
      chk("stat_clr1_b", stat_gnt1, 32'd0);
`endif

      idle(8);
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
